cc_arbiter: RTL

- Shares one circular_convolution instance between NUM_REQ independent requesters, each presenting a full parallel window.
- Grants round-robin, drives the convolution's in_valid/in_data, and tracks in-flight jobs with a credit counter plus an ID FIFO.
- Routes each out_valid/out_data result back to the requester that issued it.
- Sits between per-channel serial_to_parallel blocks and per-channel parallel_to_serial blocks.

---
 rtl/cc_pkg.sv | 18 +
 rtl/cc_id_fifo.sv | 51 +++++
 rtl/cc_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared types and helpers for the circular-convolution arbiter slice.
// Window geometry is fixed here so every block agrees on the data layout.
package cc_pkg;

  localparam int XLEN    = 16;
  localparam int WIDTH   = 128;
  localparam int MAX_REQ = 8;

  typedef logic [XLEN-1:0]     sample_t;
  typedef sample_t [WIDTH-1:0] window_t;
  typedef logic [MAX_REQ-1:0]  req_vec_t;

  // One-hot encode a requester id; callers truncate to their NUM_REQ.
  function automatic req_vec_t onehot(input int unsigned id);
    return req_vec_t'(1) << id;
  endfunction

endpackage

// File: rtl/cc_id_fifo.sv
// In-order FIFO of requester ids for jobs issued to the convolution.
// Push and pop in the same cycle are both honoured, even when full.
module cc_id_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Write the pushed id into storage.
  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end

endmodule

// File: rtl/cc_arbiter.sv
// Round-robin front end that shares one circular_convolution between
// NUM_REQ requesters, bounds in-flight jobs with a credit counter and
// routes each in-order result back to the requester that issued it.
module cc_arbiter
  import cc_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic    [NUM_REQ-1:0]           req_valid,
  output logic    [NUM_REQ-1:0]           req_ready,
  input  window_t [NUM_REQ-1:0]           req_data,
  output logic                            cc_in_valid,
  output window_t                         cc_in_data,
  input  logic                            cc_out_valid,
  input  window_t                         cc_out_data,
  output logic    [NUM_REQ-1:0]           rsp_valid,
  output window_t                         rsp_data,
  output logic    [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                            err_underflow
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_found;
  logic           can_issue;
  logic           handshake;
  logic           pop;
  logic [IDW-1:0] fifo_head;
  logic           fifo_empty;
  logic           fifo_full;

  // (base + k) mod NUM_REQ for k < NUM_REQ, without a divider.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // The FIFO-full term duplicates the credit check as a guard on the ID store.
  assign can_issue = (inflight < CNT_MAX) && !fifo_full;
  assign handshake = |(req_valid & req_ready);
  assign pop       = cc_out_valid && !fifo_empty;

  // Search req_valid from rr_ptr with wrap-around for the next grant.
  // NOTE: every variable gets a default first so no path leaves a latch.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[wrap_idx(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_id    = wrap_idx(rr_ptr, k);
      end
    end
  end

  // Drive the one-hot grant; held at zero while reset is asserted so
  // requesters never see a grant that the reset flops would discard.
  always_comb begin
    req_ready = '0;
    if (rst_n && can_issue && gnt_found) req_ready = NUM_REQ'(onehot(32'(gnt_id)));
  end

  // Move the round-robin pointer past the requester just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (handshake) begin
      rr_ptr <= wrap_idx(gnt_id, 1);
    end
  end

  // Issue register: single-cycle strobe, data held until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_in_valid <= 1'b0;
      cc_in_data  <= '0;
    end else begin
      cc_in_valid <= handshake;
      if (handshake) cc_in_data <= req_data[gnt_id];
    end
  end

  // Credit counter: issues add, owned results subtract, both cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({handshake, pop})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Response register: route the result to the FIFO-head owner for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= pop ? NUM_REQ'(onehot(32'(fifo_head))) : '0;
      if (pop) rsp_data <= cc_out_data;
    end
  end

  // Sticky flag for results that arrive with no job outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (cc_out_valid && fifo_empty) begin
      err_underflow <= 1'b1;
    end
  end

  cc_id_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (IDW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (handshake),
    .push_id (gnt_id),
    .pop     (pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule
